ysyx_25020047_lsu_mc: RTL and testbench

YSYX_25020047_LSU_MC -- requirements
Module: ysyx_25020047_lsu_mc

---
 rtl/ysyx_25020047_pkg.sv | 39 +++
 rtl/ysyx_25020047_lsu_mc_if.sv | 46 ++++
 rtl/ysyx_25020047_lsu_align.sv | 45 ++++
 rtl/ysyx_25020047_lsu_mc.sv | 169 ++++++++++++++++
 tb/tb_ysyx_25020047_lsu_mc.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the multi-cycle load/store unit: funct3 width codes,
// FSM state encoding and request legality helpers.
package ysyx_25020047_pkg;

    localparam logic [2:0] OpB  = 3'b000;
    localparam logic [2:0] OpH  = 3'b001;
    localparam logic [2:0] OpW  = 3'b010;
    localparam logic [2:0] OpBu = 3'b100;
    localparam logic [2:0] OpHu = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    // Unsigned widths only make sense for loads.
    function automatic logic op_illegal(logic [2:0] op, logic we);
        logic ill;
        case (op)
            OpB, OpH, OpW: ill = 1'b0;
            OpBu, OpHu:    ill = we;
            default:       ill = 1'b1;
        endcase
        return ill;
    endfunction

    function automatic logic op_misaligned(logic [2:0] op, logic [1:0] addr_lo);
        logic mis;
        case (op)
            OpH, OpHu: mis = addr_lo[0];
            OpW:       mis = (addr_lo != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_mc_if.sv
// Bundle of front-end request, memory-side and result signals of the LSU.
// master: the surroundings (core + memory); slave: the LSU itself.
interface ysyx_25020047_lsu_mc_if #(
    parameter int unsigned ADDR_W = 32
);
    // Front end
    logic              in_valid;
    logic              in_ready;
    logic              in_we;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;
    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    // Result
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rdata;
    logic              out_err;

    modport master (
        output in_valid, in_we, in_op, in_addr, in_wdata,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  out_valid, out_rdata, out_err,
        output out_ready
    );

    modport slave (
        input  in_valid, in_we, in_op, in_addr, in_wdata,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output out_valid, out_rdata, out_err,
        input  out_ready
    );

endinterface

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational lane logic: store byte enables and data shift, load shift and
// sign/zero extension, all keyed on the low address bits.
module ysyx_25020047_lsu_align
    import ysyx_25020047_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rdata_sh;

    assign wdata_o  = wdata_i << {addr_lo_i, 3'b000};
    assign rdata_sh = rdata_i >> {addr_lo_i, 3'b000};

    // Byte enables only for stores; loads present an all-zero mask.
    always_comb begin
        wmask_o = 4'b0000;
        if (we_i) begin
            case (op_i[1:0])
                2'b00:   wmask_o = 4'b0001 << addr_lo_i;
                2'b01:   wmask_o = 4'b0011 << addr_lo_i;
                default: wmask_o = 4'b1111;
            endcase
        end
    end

    // Truncate the shifted word to the access width, then extend.
    always_comb begin
        rdata_o = rdata_sh;
        case (op_i)
            OpB:     rdata_o = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            OpH:     rdata_o = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            OpBu:    rdata_o = {24'h0, rdata_sh[7:0]};
            OpHu:    rdata_o = {16'h0, rdata_sh[15:0]};
            default: rdata_o = rdata_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu_mc.sv
// Multi-cycle load/store unit: accepts one access at a time, issues a single
// word-aligned memory request, waits for grant and data/ack with a bounded
// timeout, and holds the result until the consumer takes it.
module ysyx_25020047_lsu_mc
    import ysyx_25020047_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,  // must match the interface instance
    parameter int unsigned TIMEOUT = 255  // >= 1
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_25020047_lsu_mc_if.slave   bus
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              out_valid_q, out_valid_d;
    logic              out_err_q, out_err_d;
    logic [31:0]       out_rdata_q, out_rdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [3:0]        wmask;
    logic [31:0]       wdata_sh;
    logic [31:0]       rdata_ext;
    logic              timeout_hit;
    logic              req_bad;

    // Lanes are derived from latched request fields, so memory outputs stay
    // stable for the whole transaction and read back as zero after reset.
    ysyx_25020047_lsu_align u_align (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .we_i      (we_q),
        .wdata_i   (wdata_q),
        .rdata_i   (bus.mem_rdata),
        .wmask_o   (wmask),
        .wdata_o   (wdata_sh),
        .rdata_o   (rdata_ext)
    );

    assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;
    assign req_bad     = op_illegal(bus.in_op, bus.in_we)
                       | op_misaligned(bus.in_op, bus.in_addr[1:0]);

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = wdata_sh;
    assign bus.mem_wmask = wmask;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rdata = out_rdata_q;
    assign bus.out_err   = out_err_q;

    // Next-state logic: acceptance, memory handshake, timeout and result hold.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        mem_req_d   = mem_req_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_rdata_d = out_rdata_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    addr_d  = bus.in_addr;
                    op_d    = bus.in_op;
                    we_d    = bus.in_we;
                    wdata_d = bus.in_wdata;
                    cnt_d   = '0;
                    if (req_bad) begin
                        state_d     = StResp;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_rdata_d = 32'h0;
                    end else begin
                        state_d   = StReq;
                        mem_req_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (bus.mem_rvalid) begin
                        state_d     = StResp;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b0;
                        out_rdata_d = we_q ? 32'h0 : rdata_ext;
                    end else begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    state_d     = StResp;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    out_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                if (bus.mem_rvalid) begin
                    state_d     = StResp;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    out_rdata_d = we_q ? 32'h0 : rdata_ext;
                end else if (timeout_hit) begin
                    state_d     = StResp;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    out_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (bus.out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                    out_rdata_d = 32'h0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset drops any open transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            op_q        <= 3'b000;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_rdata_q <= 32'h0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            mem_req_q   <= mem_req_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_rdata_q <= out_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_lsu_mc.sv
// Directed bench for the multi-cycle LSU: hand-computed expectations checked
// with immediate assertions one clock step at a time.
module tb_ysyx_25020047_lsu_mc;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ysyx_25020047_lsu_mc_if #(.ADDR_W(32)) bus ();

    ysyx_25020047_lsu_mc #(
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.in_valid = 1'b1;
        bus.in_we    = we;
        bus.in_op    = op;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_we      = 1'b0;
        bus.in_op      = 3'b000;
        bus.in_addr    = 32'h0;
        bus.in_wdata   = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.out_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_in_ready",  32'(bus.in_ready), 32'd0);
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_wmask",     32'(bus.mem_wmask), 32'd0);
        check("rst_mem_addr",  bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_err",   32'(bus.out_err), 32'd0);
        check("rst_out_rdata", bus.out_rdata, 32'h0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // LB at ...03, gnt+rvalid on first request cycle
        request(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        check("lb_mem_req",   32'(bus.mem_req), 32'd1);
        check("lb_mem_addr",  bus.mem_addr, 32'h0000_1000);
        check("lb_wmask",     32'(bus.mem_wmask), 32'd0);
        check("lb_in_ready",  32'(bus.in_ready), 32'd0);
        check("lb_not_valid", 32'(bus.out_valid), 32'd0);
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h80FF_0000;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        check("lb_out_valid", 32'(bus.out_valid), 32'd1);
        check("lb_out_rdata", bus.out_rdata, 32'hFFFF_FF80);
        check("lb_out_err",   32'(bus.out_err), 32'd0);
        check("lb_req_drop",  32'(bus.mem_req), 32'd0);
        drain();
        check("lb_back_idle", 32'(bus.out_valid), 32'd0);
        check("lb_ready_again", 32'(bus.in_ready), 32'd1);

        // SH at ...02: lanes, then WAIT for the write ack
        request(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
        tick();
        bus.in_valid = 1'b0;
        check("sh_mem_req",   32'(bus.mem_req), 32'd1);
        check("sh_mem_we",    32'(bus.mem_we), 32'd1);
        check("sh_wmask",     32'(bus.mem_wmask), 32'hC);
        check("sh_mem_wdata", bus.mem_wdata, 32'hABCD_0000);
        check("sh_mem_addr",  bus.mem_addr, 32'h0000_2000);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        check("sh_wait_req",   32'(bus.mem_req), 32'd0);
        check("sh_wait_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("sh_wait_valid2", 32'(bus.out_valid), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.mem_rvalid = 1'b0;
        check("sh_out_valid", 32'(bus.out_valid), 32'd1);
        check("sh_out_rdata", bus.out_rdata, 32'h0);
        check("sh_out_err",   32'(bus.out_err), 32'd0);
        drain();

        // LW misaligned: error response next cycle, no memory request
        request(1'b0, 3'b010, 32'h0000_3001, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        check("lwmis_valid",   32'(bus.out_valid), 32'd1);
        check("lwmis_err",     32'(bus.out_err), 32'd1);
        check("lwmis_rdata",   bus.out_rdata, 32'h0);
        check("lwmis_mem_req", 32'(bus.mem_req), 32'd0);
        drain();
        check("lwmis_mem_req2", 32'(bus.mem_req), 32'd0);

        // Illegal funct3 and unsigned store
        request(1'b0, 3'b011, 32'h0000_3000, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        check("op011_err",     32'(bus.out_err), 32'd1);
        check("op011_mem_req", 32'(bus.mem_req), 32'd0);
        drain();
        request(1'b1, 3'b100, 32'h0000_3000, 32'h55);
        tick();
        bus.in_valid = 1'b0;
        check("sbu_err",     32'(bus.out_err), 32'd1);
        check("sbu_valid",   32'(bus.out_valid), 32'd1);
        check("sbu_mem_req", 32'(bus.mem_req), 32'd0);
        drain();

        // LHU with gnt withheld: timeout after 4 REQ cycles
        request(1'b0, 3'b101, 32'h0000_4002, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_req_%0d", i), 32'(bus.mem_req), 32'd1);
            check($sformatf("to_noval_%0d", i), 32'(bus.out_valid), 32'd0);
            tick();
        end
        check("to_valid",   32'(bus.out_valid), 32'd1);
        check("to_err",     32'(bus.out_err), 32'd1);
        check("to_rdata",   bus.out_rdata, 32'h0);
        check("to_mem_req", 32'(bus.mem_req), 32'd0);
        drain();

        // LH via WAIT, then result held under backpressure with bus noise
        request(1'b0, 3'b001, 32'h0000_5000, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_8001;
        tick();
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold_rdata_%0d", i), bus.out_rdata, 32'hFFFF_8001);
            check($sformatf("hold_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        // Release the result while a new request is already waiting
        bus.out_ready = 1'b1;
        request(1'b0, 3'b100, 32'h0000_6001, 32'h0);
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.out_ready = 1'b0;
        check("rel_valid_low", 32'(bus.out_valid), 32'd0);
        check("rel_no_req",    32'(bus.mem_req), 32'd0);
        check("rel_in_ready2", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("lbu_mem_req",  32'(bus.mem_req), 32'd1);
        check("lbu_mem_addr", bus.mem_addr, 32'h0000_6000);
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_FE00;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        check("lbu_rdata", bus.out_rdata, 32'h0000_00FE);
        check("lbu_err",   32'(bus.out_err), 32'd0);
        drain();

        // Reset during WAIT, then a late rvalid
        request(1'b0, 3'b010, 32'h0000_7000, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        check("rw_mem_addr", bus.mem_addr, 32'h0000_7000);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rw_in_ready", 32'(bus.in_ready), 32'd1);
        check("rw_valid",    32'(bus.out_valid), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        tick();
        bus.mem_rvalid = 1'b0;
        check("rw_late_valid", 32'(bus.out_valid), 32'd0);
        check("rw_late_req",   32'(bus.mem_req), 32'd0);
        check("rw_late_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("rw_late_valid2", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
